// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : stopwatch_pkg
//  Purpose   : Shared BCD digit type, digit limits and packed time record.
//  Revision  : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX = 4'd9;
    localparam bcd_t TENS_MAX  = 4'd5;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
        bcd_t cs_tens;
        bcd_t cs_ones;
    } sw_time_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module    : bcd_digit_counter
//  Purpose   : One BCD digit that counts 0..limit and carries when wrapping.
//  Revision  : 1.0  initial release
// ============================================================================
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    input  bcd_t i_limit,
    output bcd_t o_digit,
    output logic o_carry
);

    bcd_t r_digit;
    logic w_at_limit;

    // ">=" keeps any out-of-range value from surviving past one increment
    assign w_at_limit = (r_digit >= i_limit);
    assign o_carry    = i_inc && w_at_limit;
    assign o_digit    = r_digit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_digit <= '0;
        end else if (i_clr) begin
            r_digit <= '0;
        end else if (i_inc) begin
            r_digit <= w_at_limit ? '0 : r_digit + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
//  Module    : stopwatch_time_counter
//  Purpose   : MM:SS.CC stopwatch counting 10 ms base-tick edges, with lap hold.
//  Revision  : 1.0  initial release
// ============================================================================
module stopwatch_time_counter
    import stopwatch_pkg::*;
(
    input  logic       i_sclk,
    input  logic       i_reset,
    input  logic       i_base_tick,
    input  logic       i_start_stop,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic       o_timerenb,
    output logic [3:0] o_cs_tens,
    output logic [3:0] o_cs_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_min_ones,
    output logic       o_lap_active,
    output logic       o_rollover
);

    logic     r_tick_q;
    logic     r_run;
    logic     r_lap_active;
    logic     r_rollover;
    sw_time_t r_lap;

    logic     w_tick_evt;
    logic     w_inc;
    logic     w_c_cs_ones, w_c_cs_tens, w_c_sec_ones;
    logic     w_c_sec_tens, w_c_min_ones, w_c_min_tens;
    bcd_t     w_cs_ones, w_cs_tens, w_sec_ones;
    bcd_t     w_sec_tens, w_min_ones, w_min_tens;
    sw_time_t w_count;
    sw_time_t w_display;

    assign w_tick_evt = (i_base_tick != r_tick_q);
    assign w_inc      = w_tick_evt && r_run;

    bcd_digit_counter u_cs_ones (
        .i_clk(i_sclk), .i_rst(i_reset), .i_inc(w_inc), .i_clr(i_clear),
        .i_limit(DIGIT_MAX), .o_digit(w_cs_ones), .o_carry(w_c_cs_ones)
    );
    bcd_digit_counter u_cs_tens (
        .i_clk(i_sclk), .i_rst(i_reset), .i_inc(w_c_cs_ones), .i_clr(i_clear),
        .i_limit(DIGIT_MAX), .o_digit(w_cs_tens), .o_carry(w_c_cs_tens)
    );
    bcd_digit_counter u_sec_ones (
        .i_clk(i_sclk), .i_rst(i_reset), .i_inc(w_c_cs_tens), .i_clr(i_clear),
        .i_limit(DIGIT_MAX), .o_digit(w_sec_ones), .o_carry(w_c_sec_ones)
    );
    bcd_digit_counter u_sec_tens (
        .i_clk(i_sclk), .i_rst(i_reset), .i_inc(w_c_sec_ones), .i_clr(i_clear),
        .i_limit(TENS_MAX), .o_digit(w_sec_tens), .o_carry(w_c_sec_tens)
    );
    bcd_digit_counter u_min_ones (
        .i_clk(i_sclk), .i_rst(i_reset), .i_inc(w_c_sec_tens), .i_clr(i_clear),
        .i_limit(DIGIT_MAX), .o_digit(w_min_ones), .o_carry(w_c_min_ones)
    );
    bcd_digit_counter u_min_tens (
        .i_clk(i_sclk), .i_rst(i_reset), .i_inc(w_c_min_ones), .i_clr(i_clear),
        .i_limit(TENS_MAX), .o_digit(w_min_tens), .o_carry(w_c_min_tens)
    );

    assign w_count = {w_min_tens, w_min_ones, w_sec_tens,
                      w_sec_ones, w_cs_tens, w_cs_ones};

    // Lap capture samples the registered count, i.e. the pre-increment time
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            r_tick_q     <= 1'b0;
            r_run        <= 1'b0;
            r_lap_active <= 1'b0;
            r_rollover   <= 1'b0;
            r_lap        <= '0;
        end else begin
            r_tick_q   <= i_base_tick;
            r_rollover <= w_c_min_tens && !i_clear;
            if (i_start_stop) begin
                r_run <= ~r_run;
            end
            if (i_clear) begin
                r_lap        <= '0;
                r_lap_active <= 1'b0;
            end else if (i_lap) begin
                if (!r_lap_active) begin
                    r_lap        <= w_count;
                    r_lap_active <= 1'b1;
                end else begin
                    r_lap_active <= 1'b0;
                end
            end
        end
    end

    assign w_display    = r_lap_active ? r_lap : w_count;
    assign o_cs_ones    = w_display.cs_ones;
    assign o_cs_tens    = w_display.cs_tens;
    assign o_sec_ones   = w_display.sec_ones;
    assign o_sec_tens   = w_display.sec_tens;
    assign o_min_ones   = w_display.min_ones;
    assign o_min_tens   = w_display.min_tens;
    assign o_timerenb   = r_run;
    assign o_lap_active = r_lap_active;
    assign o_rollover   = r_rollover;

endmodule
`default_nettype wire

// File: doc/stopwatch_time_counter.md
STOPWATCH_TIME_COUNTER -- requirements
Module: stopwatch_time_counter

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-002 i_sclk  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_base_tick  input  1  10 ms base-tick toggle from the timer block; each level change means 10 ms has elapsed.
REQ-005 i_start_stop  input  1  one-cycle pulse; toggles run state.
REQ-006 i_clear  input  1  one-cycle pulse; zeroes elapsed time.
REQ-007 i_lap  input  1  one-cycle pulse; toggles lap-hold of display outputs.
REQ-008 o_timerenb  output  1  equals run state; drives the timer's enable input.
REQ-009 o_cs_tens, o_cs_ones  output  4 each  BCD centiseconds 00-99.
REQ-010 o_sec_tens, o_sec_ones  output  4 each  BCD seconds 00-59.
REQ-011 o_min_tens, o_min_ones  output  4 each  BCD minutes 00-59.
REQ-012 o_lap_active  output  1  high while display is frozen.
REQ-013 o_rollover  output  1  one-cycle pulse on wrap 59:59.99 -> 00:00.00.

Function
REQ-014 Tick detect: registered copy tick_q of i_base_tick; tick event = (i_base_tick != tick_q) at a clock edge; tick_q updates every cycle regardless of run state.
REQ-015 A tick event while run=1 increments the internal time by 0.01 s at that same edge; the new value is visible on outputs one cycle after the i_base_tick change is sampled.
REQ-016 Tick events while run=0 are discarded; no backlog on restart.
REQ-017 Digit chain: cs_ones 9->0 carries cs_tens; cs_tens 9->0 carries sec_ones; sec_ones 9->0 carries sec_tens; sec_tens 5->0 carries min_ones; min_ones 9->0 carries min_tens; min_tens 5->0 wraps whole time to 00:00.00 and pulses o_rollover for exactly one cycle.
REQ-018 No digit ever holds a value above its limit (9, or 5 for tens of sec/min); BCD values 10-15 are unreachable.
REQ-019 i_start_stop toggles run at the edge it is sampled; a tick event in the same cycle uses the pre-toggle run value.
REQ-020 i_clear zeroes all internal digits and the lap-held digits, and clears lap-hold; run state unchanged.
REQ-021 i_clear coincident with a tick event: clear wins, result 00:00.00, no o_rollover.
REQ-022 i_clear coincident with i_start_stop: both take effect.
REQ-023 i_lap with lap-hold off: captures current internal digits into display registers, sets o_lap_active; internal counting continues.
REQ-024 i_lap with lap-hold on: releases; outputs track internal digits from next cycle.
REQ-025 i_lap coincident with a tick event: captured value is the pre-increment time.
REQ-026 Display outputs = lap registers when o_lap_active=1, else internal digits; all outputs registered, no combinational input-to-output path.

Reset
REQ-027 Reset asserted: all digits 0, run=0, o_timerenb=0, o_lap_active=0, o_rollover=0, tick_q=0.
REQ-028 Reset asserted mid-count takes effect immediately (asynchronous); first increment after release requires a fresh i_base_tick change with run=1.

Structure
REQ-029 Shared package stopwatch_pkg holds the 4-bit BCD digit typedef and limit constants (DIGIT_MAX=9, TENS_MAX=5).
REQ-030 One sub-module, bcd_digit_counter (inputs: increment enable, clear, limit; outputs: digit, carry), instantiated six times.

Verification
REQ-031 Reset, then start pulse, toggle i_base_tick 3 times -> o_timerenb=1, display 00:00.03.
REQ-032 Preload 00:59.99 via 5999 ticks, one more tick -> 01:00.00, no o_rollover.
REQ-033 Preload 59:59.99, one tick -> 00:00.00 and o_rollover high for exactly one cycle.
REQ-034 Running at 00:00.05, stop pulse, 4 ticks, start pulse, 1 tick -> 00:00.06.
REQ-035 At 00:00.10 pulse i_lap, 5 ticks -> display 00:00.10 with o_lap_active=1; second i_lap -> display 00:00.15.
REQ-036 i_clear and tick in same cycle at 00:12.34 -> 00:00.00, run unchanged; assert reset mid-count -> all outputs 0 immediately.
